// File: rtl/ysyx_22040895_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit: bus widths, reset PC,
// fetch FSM encoding and next-PC select.
package ysyx_22040895_ifu_pkg;

  localparam int unsigned          REG_BUS     = 64;
  localparam int unsigned          INST_BUS    = 32;
  localparam logic [REG_BUS-1:0]   RESET_PC_DEF = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'b00,
    S_WAIT = 2'b01,
    S_HOLD = 2'b10
  } ifu_state_t;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'b00,
    PC_TARGET = 2'b01,
    PC_INC    = 2'b10
  } pc_sel_t;

endpackage

// File: rtl/ysyx_22040895_pc_reg.sv
// PC register with asynchronous active-low reset and a target / pc+4 / hold next-PC mux.
module ysyx_22040895_pc_reg
  import ysyx_22040895_ifu_pkg::*;
#(
  parameter int unsigned     XLEN     = REG_BUS,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  pc_sel_t         sel,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_n;

  always_comb begin
    pc_n = pc;
    case (sel)
      PC_TARGET: pc_n = target;
      PC_INC:    pc_n = pc + XLEN'(4);
      default:   pc_n = pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= pc_n;
  end

endmodule

// File: rtl/ysyx_22040895_ifu.sv
// Instruction fetch unit: one outstanding req/gnt/rvalid fetch, {pc, inst} handed to decode
// with valid/ready. Optional perf counters under YSYX_22040895_IFU_PERF_EN.
module ysyx_22040895_ifu
  import ysyx_22040895_ifu_pkg::*;
#(
  parameter int unsigned     XLEN     = REG_BUS,
  parameter int unsigned     INST_W   = INST_BUS,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk_i_ifu,
  input  logic              rst_n_i_ifu,
  input  logic              redirect_i_ifu,
  input  logic [XLEN-1:0]   target_i_ifu,
  output logic              imem_req_o_ifu,
  output logic [XLEN-1:0]   imem_addr_o_ifu,
  input  logic              imem_gnt_i_ifu,
  input  logic              imem_rvalid_i_ifu,
  input  logic [INST_W-1:0] imem_rdata_i_ifu,
  output logic              inst_valid_o_ifu,
  input  logic              inst_ready_i_ifu,
  output logic [XLEN-1:0]   pc_o_ifu,
  output logic [INST_W-1:0] inst_o_ifu,
  output logic              misalign_o_ifu
`ifdef YSYX_22040895_IFU_PERF_EN
  ,
  output logic [63:0]       perf_fetch_o_ifu,
  output logic [63:0]       perf_flush_o_ifu
`endif
);

  ifu_state_t        state, state_n;
  logic              drop, drop_n;
  logic              mis_q, mis_n;
  logic              inst_we;
  logic [INST_W-1:0] inst_q, inst_d;
  pc_sel_t           pc_sel;
  logic [XLEN-1:0]   pc;
  logic              pc_mis, tgt_mis, req, req_acc;

  ysyx_22040895_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk    (clk_i_ifu),
    .rst_n  (rst_n_i_ifu),
    .sel    (pc_sel),
    .target (target_i_ifu),
    .pc     (pc)
  );

  assign pc_mis  = (pc[1:0] != 2'b00);
  assign tgt_mis = (target_i_ifu[1:0] != 2'b00);
  // A misaligned PC never reaches memory; request is also held low while reset is asserted.
  assign req     = (state == S_REQ) && !pc_mis && rst_n_i_ifu;
  assign req_acc = req && imem_gnt_i_ifu;

  always_comb begin
    state_n = state;
    drop_n  = drop;
    mis_n   = mis_q;
    inst_we = 1'b0;
    inst_d  = imem_rdata_i_ifu;
    pc_sel  = PC_HOLD;
    case (state)
      S_REQ: begin
        if (redirect_i_ifu) begin
          pc_sel = PC_TARGET;
          if (req_acc) begin
            state_n = S_WAIT;
            drop_n  = 1'b1;
          end else if (tgt_mis) begin
            state_n = S_HOLD;
            inst_we = 1'b1;
            inst_d  = '0;
            mis_n   = 1'b1;
          end
        end else if (pc_mis) begin
          state_n = S_HOLD;
          inst_we = 1'b1;
          inst_d  = '0;
          mis_n   = 1'b1;
        end else if (req_acc) begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_i_ifu) begin
          pc_sel = PC_TARGET;
          if (imem_rvalid_i_ifu) begin
            // Response consumed this cycle, so nothing is left outstanding to drop.
            drop_n = 1'b0;
            if (tgt_mis) begin
              state_n = S_HOLD;
              inst_we = 1'b1;
              inst_d  = '0;
              mis_n   = 1'b1;
            end else begin
              state_n = S_REQ;
            end
          end else begin
            drop_n = 1'b1;
          end
        end else if (imem_rvalid_i_ifu) begin
          if (drop) begin
            drop_n  = 1'b0;
            state_n = S_REQ;
          end else begin
            state_n = S_HOLD;
            inst_we = 1'b1;
            mis_n   = 1'b0;
          end
        end
      end
      S_HOLD: begin
        if (redirect_i_ifu) begin
          pc_sel  = PC_TARGET;
          state_n = S_REQ;
        end else if (inst_ready_i_ifu) begin
          pc_sel  = PC_INC;
          state_n = S_REQ;
        end
      end
      default: state_n = S_REQ;
    endcase
  end

  always_ff @(posedge clk_i_ifu or negedge rst_n_i_ifu) begin
    if (!rst_n_i_ifu) begin
      state  <= S_REQ;
      drop   <= 1'b0;
      mis_q  <= 1'b0;
      inst_q <= '0;
    end else begin
      state <= state_n;
      drop  <= drop_n;
      mis_q <= mis_n;
      if (inst_we) inst_q <= inst_d;
    end
  end

  assign imem_req_o_ifu   = req;
  assign imem_addr_o_ifu  = pc;
  assign pc_o_ifu         = pc;
  assign inst_valid_o_ifu = (state == S_HOLD);
  assign inst_o_ifu       = inst_q;
  assign misalign_o_ifu   = (state == S_HOLD) && mis_q;

`ifdef YSYX_22040895_IFU_PERF_EN
  logic flush_ev;
  assign flush_ev = redirect_i_ifu &&
                    ((state == S_WAIT) || (state == S_HOLD) || req_acc);

  always_ff @(posedge clk_i_ifu or negedge rst_n_i_ifu) begin
    if (!rst_n_i_ifu) begin
      perf_fetch_o_ifu <= '0;
      perf_flush_o_ifu <= '0;
    end else begin
      if ((state == S_HOLD) && inst_ready_i_ifu) perf_fetch_o_ifu <= perf_fetch_o_ifu + 64'd1;
      if (flush_ev) perf_flush_o_ifu <= perf_flush_o_ifu + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22040895_ifu.sv
// Directed testbench for ysyx_22040895_ifu with hand-computed expectations.
module tb_ysyx_22040895_ifu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [63:0] target;
  logic        req;
  logic [63:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        valid;
  logic        ready;
  logic [63:0] pc;
  logic [31:0] inst;
  logic        misalign;
`ifdef YSYX_22040895_IFU_PERF_EN
  logic [63:0] perf_fetch, perf_flush;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_22040895_ifu dut (
    .clk_i_ifu         (clk),
    .rst_n_i_ifu       (rst_n),
    .redirect_i_ifu    (redirect),
    .target_i_ifu      (target),
    .imem_req_o_ifu    (req),
    .imem_addr_o_ifu   (addr),
    .imem_gnt_i_ifu    (gnt),
    .imem_rvalid_i_ifu (rvalid),
    .imem_rdata_i_ifu  (rdata),
    .inst_valid_o_ifu  (valid),
    .inst_ready_i_ifu  (ready),
    .pc_o_ifu          (pc),
    .inst_o_ifu        (inst),
    .misalign_o_ifu    (misalign)
`ifdef YSYX_22040895_IFU_PERF_EN
    ,
    .perf_fetch_o_ifu  (perf_fetch),
    .perf_flush_o_ifu  (perf_flush)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect = 1'b0; target = '0; gnt = 1'b0;
    rvalid = 1'b0; rdata = '0; ready = 1'b0;
    tick(); tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", valid); end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", req); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL rst_inst got %h exp 0", inst); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL rst_mis got %b exp 0", misalign); end
    checks++; if (pc !== 64'h80000000) begin errors++; $display("FAIL rst_pc got %h exp 80000000", pc); end
    rst_n = 1'b1;
    #1;
    checks++; if (req !== 1'b1 || addr !== 64'h80000000) begin
      errors++; $display("FAIL rst_first_req got %b/%h exp 1/80000000", req, addr); end
  endtask

  task automatic test_basic_fetch();
    gnt = 1'b1; tick(); gnt = 1'b0;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL wait_req got %b exp 0", req); end
    rvalid = 1'b1; rdata = 32'h00000013; tick(); rvalid = 1'b0;
    checks++; if (valid !== 1'b1 || pc !== 64'h80000000 || inst !== 32'h00000013) begin
      errors++; $display("FAIL basic_present got %b/%h/%h exp 1/80000000/00000013", valid, pc, inst); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL basic_mis got %b exp 0", misalign); end
    ready = 1'b1; tick(); ready = 1'b0;
    checks++; if (valid !== 1'b0 || req !== 1'b1 || addr !== 64'h80000004) begin
      errors++; $display("FAIL basic_next got %b/%b/%h exp 0/1/80000004", valid, req, addr); end
  endtask

  task automatic test_stall();
    gnt = 1'b1; tick(); gnt = 1'b0;
    rvalid = 1'b1; rdata = 32'h00100093; tick(); rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (valid !== 1'b1 || req !== 1'b0 || pc !== 64'h80000004 || inst !== 32'h00100093) begin
        errors++; $display("FAIL stall_%0d got %b/%b/%h/%h exp 1/0/80000004/00100093", i, valid, req, pc, inst); end
      tick();
    end
    ready = 1'b1; tick(); ready = 1'b0;
    checks++; if (req !== 1'b1 || addr !== 64'h80000008) begin
      errors++; $display("FAIL stall_next got %b/%h exp 1/80000008", req, addr); end
  endtask

  task automatic test_redirect_wait();
    gnt = 1'b1; tick(); gnt = 1'b0;
    redirect = 1'b1; target = 64'h80000100; tick(); redirect = 1'b0;
    checks++; if (req !== 1'b0 || valid !== 1'b0) begin
      errors++; $display("FAIL rdw_wait got %b/%b exp 0/0", req, valid); end
    rvalid = 1'b1; rdata = 32'hDEADBEEF; tick(); rvalid = 1'b0;
    checks++; if (valid !== 1'b0 || req !== 1'b1 || addr !== 64'h80000100) begin
      errors++; $display("FAIL rdw_drop got %b/%b/%h exp 0/1/80000100", valid, req, addr); end
    gnt = 1'b1; tick(); gnt = 1'b0;
    rvalid = 1'b1; rdata = 32'h00200113; tick(); rvalid = 1'b0;
    checks++; if (valid !== 1'b1 || pc !== 64'h80000100 || inst !== 32'h00200113) begin
      errors++; $display("FAIL rdw_refetch got %b/%h/%h exp 1/80000100/00200113", valid, pc, inst); end
    ready = 1'b1; tick(); ready = 1'b0;
    checks++; if (addr !== 64'h80000104) begin errors++; $display("FAIL rdw_next got %h exp 80000104", addr); end
  endtask

  task automatic test_redirect_rvalid_same();
    gnt = 1'b1; tick(); gnt = 1'b0;
    redirect = 1'b1; target = 64'h80000200; rvalid = 1'b1; rdata = 32'hDEADBEEF;
    tick(); redirect = 1'b0; rvalid = 1'b0;
    checks++; if (valid !== 1'b0 || req !== 1'b1 || addr !== 64'h80000200) begin
      errors++; $display("FAIL rrs_req got %b/%b/%h exp 0/1/80000200", valid, req, addr); end
    tick();
    checks++; if (valid !== 1'b0 || req !== 1'b1) begin
      errors++; $display("FAIL rrs_idle got %b/%b exp 0/1", valid, req); end
  endtask

  task automatic test_misalign();
    redirect = 1'b1; target = 64'h80000102; tick(); redirect = 1'b0;
    checks++; if (req !== 1'b0 || valid !== 1'b1 || misalign !== 1'b1 || inst !== 32'h0 || pc !== 64'h80000102) begin
      errors++; $display("FAIL mis_present got %b/%b/%b/%h/%h exp 0/1/1/0/80000102", req, valid, misalign, inst, pc); end
    ready = 1'b1; tick(); ready = 1'b0;
    checks++; if (req !== 1'b0 || valid !== 1'b0 || pc !== 64'h80000106) begin
      errors++; $display("FAIL mis_consume got %b/%b/%h exp 0/0/80000106", req, valid, pc); end
    redirect = 1'b1; target = 64'h80000300; tick(); redirect = 1'b0;
    checks++; if (req !== 1'b1 || addr !== 64'h80000300 || misalign !== 1'b0 || valid !== 1'b0) begin
      errors++; $display("FAIL mis_clear got %b/%h/%b/%b exp 1/80000300/0/0", req, addr, misalign, valid); end
  endtask

  task automatic test_redirect_hold_ready();
    gnt = 1'b1; tick(); gnt = 1'b0;
    rvalid = 1'b1; rdata = 32'h00300193; tick(); rvalid = 1'b0;
    redirect = 1'b1; target = 64'h80000400; ready = 1'b1; tick(); redirect = 1'b0; ready = 1'b0;
    checks++; if (valid !== 1'b0 || req !== 1'b1 || addr !== 64'h80000400) begin
      errors++; $display("FAIL rhr got %b/%b/%h exp 0/1/80000400", valid, req, addr); end
  endtask

  task automatic test_reset_mid_fetch();
    gnt = 1'b1; tick(); gnt = 1'b0;
    rst_n = 1'b0; #1;
    checks++; if (valid !== 1'b0 || req !== 1'b0 || misalign !== 1'b0 || inst !== 32'h0 || pc !== 64'h80000000) begin
      errors++; $display("FAIL rmid_clear got %b/%b/%b/%h/%h exp 0/0/0/0/80000000", valid, req, misalign, inst, pc); end
`ifdef YSYX_22040895_IFU_PERF_EN
    checks++; if (perf_fetch !== 64'd0 || perf_flush !== 64'd0) begin
      errors++; $display("FAIL rmid_perf got %0d/%0d exp 0/0", perf_fetch, perf_flush); end
`endif
    rvalid = 1'b1; rdata = 32'hDEADBEEF; tick(); rvalid = 1'b0;
    rst_n = 1'b1; #1;
    checks++; if (req !== 1'b1 || addr !== 64'h80000000 || valid !== 1'b0) begin
      errors++; $display("FAIL rmid_req got %b/%h/%b exp 1/80000000/0", req, addr, valid); end
    tick();
    checks++; if (valid !== 1'b0 || req !== 1'b1) begin
      errors++; $display("FAIL rmid_stale got %b/%b exp 0/1", valid, req); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid_same();
    test_misalign();
    test_redirect_hold_ready();
    test_reset_mid_fetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
